sa_input_skew: RTL and testbench
================================

SA_INPUT_SKEW -- requirements
Module: sa_input_skew

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of one activation element.
REQ-002 SHALL have parameter NEURON_NUM, default 4, number of systolic-array rows/lanes (legal range 1..16).
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous abort; highest priority after rstn.
REQ-006 SHALL have port in_valid_i  input  1  input vector valid.
REQ-007 SHALL have port in_ready_o  output  1  block can accept an input vector.
REQ-008 SHALL have port in_data_i  input  DATA_WIDTH*NEURON_NUM  signed input vector; lane k = bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH].
REQ-009 SHALL have port in_last_i  input  1  marks the final vector of a batch; sampled only on accepted beats.
REQ-010 SHALL have port skew_data_o  output  DATA_WIDTH*NEURON_NUM  staggered data to systolic array, same lane packing.
REQ-011 SHALL have port acc_en_o  output  1  systolic-array step enable, aligned with skew_data_o.
REQ-012 SHALL have port vec_cnt_o  output  8  accepted vectors in current batch, saturating at 255.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse when a batch has fully drained.

Function
REQ-014 SHALL implement states IDLE, STREAM, FLUSH, DONE.
REQ-015 SHALL assert in_ready_o combinationally in IDLE and STREAM only; deasserted in FLUSH and DONE.
REQ-016 SHALL define accept = in_valid_i & in_ready_o; define step = accept | (state==FLUSH).
REQ-017 SHALL, per lane k, hold a k-stage delay line plus one output register (lane latency k+1 cycles), advancing only on step.
REQ-018 SHALL push in_data_i into the delay lines on accept, and a zero vector on FLUSH steps.
REQ-019 SHALL hold delay lines and skew_data_o unchanged when step=0 (stall freezes array, no bubble inserted).
REQ-020 SHALL drive acc_en_o as step registered by one cycle, so acc_en_o=1 exactly in cycles where skew_data_o carries a new value.
REQ-021 SHALL transition IDLE->STREAM on accept with in_last_i=0; IDLE or STREAM ->FLUSH on accept with in_last_i=1 when NEURON_NUM>1, ->DONE when NEURON_NUM=1.
REQ-022 SHALL remain in FLUSH for exactly NEURON_NUM-1 cycles (4-bit down counter), then go to DONE.
REQ-023 SHALL, in DONE, pulse done_o for one cycle, clear vec_cnt_o, and return to IDLE next cycle.
REQ-024 SHALL increment vec_cnt_o on each accept, holding at 255 on overflow.
REQ-025 SHALL, on clear_i=1, return to IDLE, zero all delay lines, skew_data_o, acc_en_o, vec_cnt_o, and the flush counter; done_o not pulsed.
REQ-026 SHALL treat in_valid_i during FLUSH/DONE as not accepted; data is not consumed.

Reset
REQ-027 SHALL, while rstn=0, force state=IDLE, skew_data_o=0, acc_en_o=0, vec_cnt_o=0, done_o=0, delay lines and counter =0.
REQ-028 SHALL, on rstn assertion mid-batch, discard all in-flight data; first cycle after release is IDLE with in_ready_o=1.

Verification
REQ-029 SHALL cover: NEURON_NUM=4, vectors {1,2,3,4},{5,6,7,8} contiguous, last on 2nd -> lane0 outputs 1,5 at cycles 1,2; lane3 outputs 4,8 at cycles 4,5; acc_en_o high 5 cycles; done_o pulse once; vec_cnt_o=2 before clear.
REQ-030 SHALL cover: in_valid_i low 3 cycles between two beats in STREAM -> acc_en_o low 3 cycles, skew_data_o frozen, final lane values identical to contiguous case.
REQ-031 SHALL cover: single vector {9,9,9,9} with in_last_i=1 from IDLE -> FLUSH 3 cycles, in_ready_o=0 for 4 cycles, done_o pulse, lane3 emits 9 four cycles after accept.
REQ-032 SHALL cover: clear_i asserted in 2nd FLUSH cycle -> next cycle IDLE, skew_data_o=0, acc_en_o=0, no done_o.
REQ-033 SHALL cover: 300 contiguous beats -> vec_cnt_o saturates at 255, output stream unaffected.
REQ-034 SHALL cover: rstn pulsed low during STREAM -> all outputs 0 asynchronously, in_ready_o=1 after release.

Source files
------------

// File: rtl/sa_input_skew.sv
// sa_input_skew
//   Input skew buffer in front of a systolic array. Each accepted input
//   vector is staggered so that lane k reaches the array k cycles after
//   lane 0. Lane k uses a k-stage delay line plus one output register,
//   so its latency is k+1 steps. The pipeline advances only on "step":
//   an accepted beat, or a flush cycle that pushes zeros to drain the
//   array once the last vector of a batch has gone in.
//
// Ports
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   clear_i      synchronous abort, returns to IDLE and zeroes all state
//   in_valid_i   input vector valid
//   in_ready_o   block can accept a vector (IDLE / STREAM only)
//   in_data_i    input vector, lane k = [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]
//   in_last_i    final vector of a batch, sampled on accepted beats
//   skew_data_o  staggered vector to the array, same lane packing
//   acc_en_o     array step enable, aligned with skew_data_o
//   vec_cnt_o    accepted vectors in the current batch, saturates at 255
//   done_o       one-cycle pulse once the batch has fully drained
module sa_input_skew #(
   parameter int DATA_WIDTH = 16,
   parameter int NEURON_NUM = 4
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             clear_i,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [DATA_WIDTH*NEURON_NUM-1:0] in_data_i,
   input  logic                             in_last_i,
   output logic [DATA_WIDTH*NEURON_NUM-1:0] skew_data_o,
   output logic                             acc_en_o,
   output logic [7:0]                       vec_cnt_o,
   output logic                             done_o
);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   // The flush counter is loaded with NEURON_NUM-2 and counts down to zero,
   // giving exactly NEURON_NUM-1 flush cycles.
   localparam logic [3:0] FLUSH_LOAD = (NEURON_NUM > 1) ? 4'(NEURON_NUM - 2) : 4'd0;

   state_t                           state, state_nxt;
   logic   [3:0]                     flush_cnt;
   logic                             accept;
   logic                             step;
   logic   [DATA_WIDTH*NEURON_NUM-1:0] push_vec;

   // NOTE: every signal written here gets a default first, so no path
   // through the block can leave a value held and infer a latch.
   always_comb begin
      in_ready_o = (state == IDLE) || (state == STREAM);
      accept     = in_valid_i & in_ready_o;
      step       = accept | (state == FLUSH);
      // Lanes carry signed data, but the buffer only moves bits; zeros are
      // pushed on flush steps so the array sees a clean tail.
      push_vec   = accept ? in_data_i : '0;
      // An abort in the DONE cycle suppresses the completion pulse.
      done_o     = (state == DONE) && !clear_i;
      state_nxt  = state;

      unique case (state)
         IDLE, STREAM: begin
            if (accept) begin
               if (!in_last_i)          state_nxt = STREAM;
               else if (NEURON_NUM > 1) state_nxt = FLUSH;
               else                     state_nxt = DONE;
            end
         end
         FLUSH: begin
            if (flush_cnt == 4'd0) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (clear_i) state_nxt = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement or process order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_en_o  <= 1'b0;
         vec_cnt_o <= 8'd0;
         flush_cnt <= 4'd0;
      end else if (clear_i) begin
         acc_en_o  <= 1'b0;
         vec_cnt_o <= 8'd0;
         flush_cnt <= 4'd0;
      end else begin
         // acc_en_o follows step by one cycle: it is high exactly when the
         // output registers have just taken a new value.
         acc_en_o <= step;

         if (state == DONE)
            vec_cnt_o <= 8'd0;
         else if (accept && (vec_cnt_o != 8'hFF))
            vec_cnt_o <= vec_cnt_o + 8'd1;

         if ((state != FLUSH) && (state_nxt == FLUSH))
            flush_cnt <= FLUSH_LOAD;
         else if ((state == FLUSH) && (flush_cnt != 4'd0))
            flush_cnt <= flush_cnt - 4'd1;
      end
   end

   // Per-lane delay line; line[k] is the output register of lane k.
   for (genvar k = 0; k < NEURON_NUM; k++) begin : g_lane
      logic [DATA_WIDTH-1:0] line [0:k];

      // NOTE: the delay-line array is reset element by element because
      // in-flight data must be discarded on reset and abort; a plain RAM
      // without reset would leak stale vectors into the next batch.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i <= k; i++) line[i] <= '0;
         end else if (clear_i) begin
            for (int i = 0; i <= k; i++) line[i] <= '0;
         end else if (step) begin
            line[0] <= push_vec[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH];
            for (int i = 1; i <= k; i++) line[i] <= line[i-1];
         end
      end

      assign skew_data_o[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH] = line[k];
   end

endmodule

// File: tb/tb_sa_input_skew.sv
// Testbench for sa_input_skew (DATA_WIDTH=16, NEURON_NUM=4).
// Directed cycle tables for the documented batch scenarios, then random
// traffic compared every cycle against a step-history reference model.
module tb_sa_input_skew;

   localparam int DW = 16;
   localparam int N  = 4;
   localparam int W  = DW * N;

   logic         clk;
   logic         rstn;
   logic         clear_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [W-1:0] in_data_i;
   logic         in_last_i;
   logic [W-1:0] skew_data_o;
   logic         acc_en_o;
   logic [7:0]   vec_cnt_o;
   logic         done_o;

   int n_cmp = 0;
   int n_err = 0;

   sa_input_skew #(.DATA_WIDTH(DW), .NEURON_NUM(N)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .clear_i    (clear_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .in_last_i  (in_last_i),
      .skew_data_o(skew_data_o),
      .acc_en_o   (acc_en_o),
      .vec_cnt_o  (vec_cnt_o),
      .done_o     (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pk(input int a, input int b, input int c, input int d);
      return {DW'(d), DW'(c), DW'(b), DW'(a)};
   endfunction

   // ---------------- directed cycle table ----------------
   // One record per cycle: inputs driven in that cycle and outputs expected
   // to be visible in that same cycle (before the rising edge).
   typedef struct {
      logic         v, l, clr;
      logic [W-1:0] data;
      logic         e_ready;
      logic [DW-1:0] e_l0, e_l3;
      logic         e_acc, e_done;
      logic [7:0]   e_cnt;
   } rec_t;

   rec_t tbl[$];

   task automatic add(input logic v, l, clr, input logic [W-1:0] data,
                      input logic rdy, input int l0, input int l3,
                      input logic acc, input logic dn, input int cnt);
      rec_t r;
      r.v = v; r.l = l; r.clr = clr; r.data = data;
      r.e_ready = rdy; r.e_l0 = DW'(l0); r.e_l3 = DW'(l3);
      r.e_acc = acc; r.e_done = dn; r.e_cnt = 8'(cnt);
      tbl.push_back(r);
   endtask

   // ---------------- reference model ----------------
   // hist holds the vector pushed on each step (newest last); lane k shows
   // the vector pushed k steps before the newest one. m_left counts the
   // cycles still to go before the block is ready again: N-1 flush cycles
   // followed by one done cycle.
   logic [W-1:0] hist[$];
   int           m_left;
   int           m_count;
   logic         m_acc;

   task automatic model_reset();
      hist.delete();
      m_left  = 0;
      m_count = 0;
      m_acc   = 1'b0;
   endtask

   function automatic logic [W-1:0] m_skew();
      logic [W-1:0] r;
      int idx;
      r = '0;
      for (int k = 0; k < N; k++) begin
         idx = hist.size() - 1 - k;
         if (idx >= 0) r[DW*k +: DW] = hist[idx][DW*k +: DW];
      end
      return r;
   endfunction

   task automatic model_cycle(input logic v, input logic l, input logic clr, input logic [W-1:0] d);
      logic acc_ok;
      logic stp;
      @(negedge clk);
      in_valid_i = v; in_last_i = l; clear_i = clr; in_data_i = d;
      #1;
      check("model ready", W'(in_ready_o), W'(m_left == 0));
      check("model done",  W'(done_o),     W'((m_left == 1) && !clr));
      check("model skew",  skew_data_o,    m_skew());
      check("model acc",   W'(acc_en_o),   W'(m_acc));
      check("model cnt",   W'(vec_cnt_o),  W'((m_count > 255) ? 255 : m_count));
      if (clr) begin
         model_reset();
      end else begin
         acc_ok = v && (m_left == 0);
         stp    = acc_ok || (m_left > 1);
         if (stp) begin
            hist.push_back(acc_ok ? d : '0);
            if (hist.size() > N) void'(hist.pop_front());
         end
         m_acc = stp;
         if (acc_ok) m_count++;
         if (m_left == 1) m_count = 0;
         if (m_left > 0) m_left--;
         else if (acc_ok && l) m_left = N;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0; clear_i = 1'b0; in_data_i = '0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
   endtask

   initial begin
      rstn = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0; in_data_i = '0;
      #2;
      check("reset skew",  skew_data_o,      '0);
      check("reset acc",   W'(acc_en_o),     '0);
      check("reset cnt",   W'(vec_cnt_o),    '0);
      check("reset done",  W'(done_o),       '0);
      check("reset ready", W'(in_ready_o),   W'(1));
      @(negedge clk);
      rstn = 1'b1;

      // Contiguous two-vector batch
      add(1,0,0, pk(1,2,3,4), 1, 0,0, 0,0, 0);
      add(1,1,0, pk(5,6,7,8), 1, 1,0, 1,0, 1);
      add(0,0,0, '0,          0, 5,0, 1,0, 2);
      add(0,0,0, '0,          0, 0,0, 1,0, 2);
      add(0,0,0, '0,          0, 0,4, 1,0, 2);
      add(0,0,0, '0,          0, 0,8, 1,1, 2);
      add(0,0,0, '0,          1, 0,8, 0,0, 0);
      // Same batch with a 3-cycle valid gap in STREAM
      add(1,0,0, pk(1,2,3,4), 1, 0,8, 0,0, 0);
      add(0,0,0, '0,          1, 1,0, 1,0, 1);
      add(0,0,0, '0,          1, 1,0, 0,0, 1);
      add(0,0,0, '0,          1, 1,0, 0,0, 1);
      add(1,1,0, pk(5,6,7,8), 1, 1,0, 0,0, 1);
      add(0,0,0, '0,          0, 5,0, 1,0, 2);
      add(0,0,0, '0,          0, 0,0, 1,0, 2);
      add(0,0,0, '0,          0, 0,4, 1,0, 2);
      add(0,0,0, '0,          0, 0,8, 1,1, 2);
      add(0,0,0, '0,          1, 0,8, 0,0, 0);
      // Single-vector batch; valid held high while not ready must be ignored
      add(1,1,0, pk(9,9,9,9), 1, 0,8, 0,0, 0);
      add(1,0,0, pk(7,7,7,7), 0, 9,0, 1,0, 1);
      add(1,0,0, pk(7,7,7,7), 0, 0,0, 1,0, 1);
      add(1,1,0, pk(7,7,7,7), 0, 0,0, 1,0, 1);
      add(1,0,0, pk(7,7,7,7), 0, 0,9, 1,1, 1);
      add(0,0,0, '0,          1, 0,9, 0,0, 0);
      // Abort in the second flush cycle
      add(1,1,0, pk(1,2,3,4), 1, 0,9, 0,0, 0);
      add(0,0,0, '0,          0, 1,0, 1,0, 1);
      add(0,0,1, '0,          0, 0,0, 1,0, 1);
      add(0,0,0, '0,          1, 0,0, 0,0, 0);
      add(0,0,0, '0,          1, 0,0, 0,0, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         in_valid_i = tbl[i].v; in_last_i = tbl[i].l; clear_i = tbl[i].clr; in_data_i = tbl[i].data;
         #1;
         check($sformatf("tbl%0d ready", i), W'(in_ready_o),        W'(tbl[i].e_ready));
         check($sformatf("tbl%0d lane0", i), W'(skew_data_o[15:0]), W'(tbl[i].e_l0));
         check($sformatf("tbl%0d lane3", i), W'(skew_data_o[63:48]), W'(tbl[i].e_l3));
         check($sformatf("tbl%0d acc",   i), W'(acc_en_o),          W'(tbl[i].e_acc));
         check($sformatf("tbl%0d done",  i), W'(done_o),            W'(tbl[i].e_done));
         check($sformatf("tbl%0d cnt",   i), W'(vec_cnt_o),         W'(tbl[i].e_cnt));
      end
      check("abort full skew zero", skew_data_o, '0);

      // 300 contiguous beats: counter saturates, stream unaffected
      do_reset();
      for (int i = 0; i < 300; i++)
         model_cycle(1'b1, (i == 299), 1'b0, pk(i, i + 1000, i + 2000, i + 3000));
      check("saturated cnt", W'(vec_cnt_o), W'(255));
      for (int i = 0; i < N + 2; i++) model_cycle(1'b0, 1'b0, 1'b0, '0);

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++)
         model_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 49) == 0, {$urandom, $urandom});

      // Asynchronous reset in the middle of a batch
      do_reset();
      model_cycle(1'b1, 1'b0, 1'b0, pk(11, 12, 13, 14));
      model_cycle(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("async rst skew",  skew_data_o,    '0);
      check("async rst acc",   W'(acc_en_o),   '0);
      check("async rst cnt",   W'(vec_cnt_o),  '0);
      check("async rst done",  W'(done_o),     '0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("post rst ready",  W'(in_ready_o), W'(1));
      check("post rst skew",   skew_data_o,    '0);
      model_reset();
      model_cycle(1'b1, 1'b1, 1'b0, pk(21, 22, 23, 24));
      for (int i = 0; i < N + 2; i++) model_cycle(1'b0, 1'b0, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
